// File: rtl/led_seq_pkg.sv
// ============================================================================
// Module      : led_seq_pkg
// Description : Shared types, address map and pattern-step helper for the LED
//               sequencer/arbiter. Macro LED_SEQ_RGB_EN adds the RGB states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_seq_pkg;

    localparam logic [1:0] ADDR_LED  = 2'd0;
    localparam logic [1:0] ADDR_RGBA = 2'd1;
    localparam logic [1:0] ADDR_RGBB = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;

    typedef enum logic [1:0] {
        MODE_ROT    = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

`ifdef LED_SEQ_RGB_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_WR_LED  = 3'd2,
        ST_WR_RGBA = 3'd3,
        ST_WR_RGBB = 3'd4
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_WR_LED = 2'd2
    } state_e;
`endif

    typedef struct packed {
        logic [7:0] pattern;
        dir_e       dir;
    } step_t;

    function automatic step_t next_step(input mode_e mode, input logic [7:0] p, input dir_e dir);
        step_t r;
        dir_e  d;
        r.pattern = p;
        r.dir     = dir;
        d         = dir;
        case (mode)
            MODE_ROT: begin
                r.pattern = (p == 8'h00) ? 8'h01 : {p[6:0], p[7]};
            end
            MODE_BOUNCE: begin
                if (p == 8'h00) begin
                    r.pattern = 8'h01;
                end else begin
                    // A seed already at the edge we are heading toward turns around first
                    if (d == DIR_LEFT && p[7]) begin
                        d = DIR_RIGHT;
                    end else if (d == DIR_RIGHT && p[0]) begin
                        d = DIR_LEFT;
                    end
                    r.pattern = (d == DIR_LEFT) ? {p[6:0], 1'b0} : {1'b0, p[7:1]};
                    if (r.pattern[7]) begin
                        r.dir = DIR_RIGHT;
                    end else if (r.pattern[0]) begin
                        r.dir = DIR_LEFT;
                    end else begin
                        r.dir = d;
                    end
                end
            end
            MODE_BLINK: begin
                r.pattern = ~p;
            end
            default: begin
                r.pattern = p + 8'h01;
            end
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_seq_prescaler.sv
// ============================================================================
// Module      : led_seq_prescaler
// Description : Step prescaler; pulses tick every max(cfg_period,1) cycles
//               while enabled, held at zero when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_seq_prescaler
    import led_seq_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_period,
    output logic             tick
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] last_cnt;

    // A zero period is treated as one: tick every enabled cycle
    assign last_cnt = (cfg_period == '0) ? '0 : cfg_period - CNT_W'(1);
    assign tick     = en && (count_q == last_cnt);

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (!en || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_seq_arb.sv
// ============================================================================
// Module      : led_seq_arb
// Description : Arbitrates the LED register-file write port between the host
//               and an autonomous pattern engine; slot 3 is its control reg.
//               Macro LED_SEQ_RGB_EN adds rgbA/rgbB writes after each led write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_seq_arb
    import led_seq_pkg::*;
#(
    parameter int         CNT_W       = 24,
    parameter logic [7:0] RST_PATTERN = 8'h01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       h_addr,
    input  logic [7:0]       h_wdata,
    input  logic             h_wen,
    output logic [7:0]       h_rdata,
    input  logic [CNT_W-1:0] cfg_period,
    output logic [1:0]       d_addr,
    output logic [7:0]       d_wdata,
    output logic             d_wen,
    input  logic [7:0]       d_rdata,
    output logic             seq_active,
    output logic             step_drop
);

    logic [2:0] ctrl_q,    ctrl_d;
    logic [7:0] pattern_q, pattern_d;
    dir_e       dir_q,     dir_d;
    state_e     state_q,   state_d;
`ifdef LED_SEQ_RGB_EN
    logic [2:0] color_q,   color_d;
`endif

    logic       en;
    logic       tick;
    logic       pending;
    logic       host_fwd;
    logic       host_led_wr;
    logic       host_ctrl_wr;
    logic       eng_wr;
    logic       drop;
    logic [1:0] eng_addr;
    logic [7:0] eng_data;
    step_t      nxt;

    assign en           = ctrl_q[CTRL_EN_BIT];
    assign host_fwd     = h_wen && (h_addr != ADDR_CTRL);
    assign host_led_wr  = h_wen && (h_addr == ADDR_LED);
    assign host_ctrl_wr = h_wen && (h_addr == ADDR_CTRL);

`ifdef LED_SEQ_RGB_EN
    assign pending = (state_q == ST_WR_LED) || (state_q == ST_WR_RGBA) || (state_q == ST_WR_RGBB);
`else
    assign pending = (state_q == ST_WR_LED);
`endif

    // Engine only takes the port on host-idle cycles and never once EN is clear
    assign eng_wr = en && pending && !h_wen;

    led_seq_prescaler #(
        .CNT_W      (CNT_W)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_period (cfg_period),
        .tick       (tick)
    );

    always_comb begin
        ctrl_d    = ctrl_q;
        pattern_d = pattern_q;
        dir_d     = dir_q;
        state_d   = state_q;
        drop      = 1'b0;
        eng_addr  = ADDR_LED;
        eng_data  = pattern_q;
        nxt       = next_step(mode_e'(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]), pattern_q, dir_q);
`ifdef LED_SEQ_RGB_EN
        color_d   = color_q;
        case (state_q)
            ST_WR_RGBA: begin
                eng_addr = ADDR_RGBA;
                eng_data = {5'b0, color_q};
            end
            ST_WR_RGBB: begin
                eng_addr = ADDR_RGBB;
                eng_data = {5'b0, ~color_q};
            end
            default: ;
        endcase
`endif

        if (host_ctrl_wr) begin
            ctrl_d = h_wdata[2:0];
        end
        if (host_led_wr) begin
            pattern_d = h_wdata;
        end

        if (!en) begin
            state_d = ST_IDLE;
        end else if (pending) begin
            if (tick && !host_led_wr) begin
                drop = 1'b1;
            end
            if (eng_wr) begin
`ifdef LED_SEQ_RGB_EN
                case (state_q)
                    ST_WR_LED:  state_d = ST_WR_RGBA;
                    ST_WR_RGBA: state_d = ST_WR_RGBB;
                    default:    state_d = ST_RUN;
                endcase
`else
                state_d = ST_RUN;
`endif
            end
        end else begin
            state_d = ST_RUN;
            // A host seed of the led slot in a tick cycle discards the step
            if (tick && !host_led_wr) begin
                pattern_d = nxt.pattern;
                dir_d     = nxt.dir;
                state_d   = ST_WR_LED;
`ifdef LED_SEQ_RGB_EN
                color_d   = color_q + 3'd1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q    <= 3'b000;
            pattern_q <= RST_PATTERN;
            dir_q     <= DIR_LEFT;
            state_q   <= ST_IDLE;
`ifdef LED_SEQ_RGB_EN
            color_q   <= 3'b000;
`endif
        end else begin
            ctrl_q    <= ctrl_d;
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            state_q   <= state_d;
`ifdef LED_SEQ_RGB_EN
            color_q   <= color_d;
`endif
        end
    end

    assign d_addr     = eng_wr ? eng_addr : h_addr;
    assign d_wdata    = eng_wr ? eng_data : h_wdata;
    assign d_wen      = rst_n && (host_fwd || eng_wr);
    assign h_rdata    = (h_addr == ADDR_CTRL) ? {5'b0, ctrl_q} : d_rdata;
    assign seq_active = en;
    assign step_drop  = rst_n && drop;

endmodule

`default_nettype wire

// File: tb/tb_led_seq_arb.sv
// ============================================================================
// Module      : tb_led_seq_arb
// Description : Scoreboard bench for led_seq_arb; expected register-file writes
//               are queued by the stimulus and popped by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_seq_arb;

    localparam int CNT_W = 24;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       h_addr;
    logic [7:0]       h_wdata;
    logic             h_wen;
    logic [7:0]       h_rdata;
    logic [CNT_W-1:0] cfg_period;
    logic [1:0]       d_addr;
    logic [7:0]       d_wdata;
    logic             d_wen;
    logic [7:0]       d_rdata;
    logic             seq_active;
    logic             step_drop;

    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         drops    = 0;
    logic [7:0] regs [4];

    led_seq_arb #(
        .CNT_W       (CNT_W),
        .RST_PATTERN (8'h01)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_addr     (h_addr),
        .h_wdata    (h_wdata),
        .h_wen      (h_wen),
        .h_rdata    (h_rdata),
        .cfg_period (cfg_period),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wen      (d_wen),
        .d_rdata    (d_rdata),
        .seq_active (seq_active),
        .step_drop  (step_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (d_wen) regs[d_addr] <= d_wdata;
    end
    assign d_rdata = regs[d_addr];

    always @(negedge clk) begin
        if (rst_n && step_drop) drops = drops + 1;
        if (rst_n && d_wen) begin
            n_checks = n_checks + 1;
            if (q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL wr_unexpected: got addr=%0d data=%h cycle=%0d, required no write", d_addr, d_wdata, cyc);
            end else begin
                mon_e = q.pop_front();
                if (d_addr !== mon_e.a || d_wdata !== mon_e.d || (mon_e.c >= 0 && cyc != mon_e.c)) begin
                    n_fail = n_fail + 1;
                    $display("FAIL wr_match: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                             d_addr, d_wdata, cyc, mon_e.a, mon_e.d, mon_e.c);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks = n_checks + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] a, input logic [7:0] d, input int c);
        exp_t e;
        e.a = a;
        e.d = d;
        e.c = c;
        q.push_back(e);
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
        h_addr  = a;
        h_wdata = d;
        h_wen   = 1'b1;
        if (a != 2'd3) push(a, d, cyc);
        @(posedge clk);
        #1;
        h_wen = 1'b0;
    endtask

    task automatic drain(input string name, input int n);
        int k;
        k = 0;
        while (q.size() != 0 && k < n) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 4; i++) regs[i] = 8'h00;
        rst_n      = 1'b0;
        h_addr     = 2'd0;
        h_wdata    = 8'h55;
        h_wen      = 1'b1;
        cfg_period = 4;
        cyc_wait(2);
        chk("rst_d_wen", d_wen, 1'b0);
        chk("rst_seq_active", seq_active, 1'b0);
        chk("rst_step_drop", step_drop, 1'b0);
        h_wen = 1'b0;
        rst_n = 1'b1;

        // Reset values and host pass-through
        h_addr = 2'd3;
        #1;
        chk("rst_ctrl_rd", h_rdata, 8'h00);
        host_wr(2'd0, 8'hA5);
        h_addr = 2'd0;
        #1;
        chk("led_readback", h_rdata, 8'hA5);

`ifdef LED_SEQ_RGB_EN
        cfg_period = 8;
        t = cyc;
        push(2'd0, 8'h4B, t + 9);
        push(2'd1, 8'h01, t + 10);
        push(2'd2, 8'h06, t + 11);
        push(2'd0, 8'h96, t + 17);
        push(2'd1, 8'h02, t + 18);
        push(2'd2, 8'h05, t + 19);
        host_wr(2'd3, 8'h01);
        cyc_wait(19);
        host_wr(2'd3, 8'h00);
        cyc_wait(4);
        drain("rgb_drain", 10);
`else
        // Count mode from the host seed, period 1
        cfg_period = 1;
        t = cyc;
        push(2'd0, 8'hA6, t + 2);
        host_wr(2'd3, 8'h07);
        cyc_wait(2);
        host_wr(2'd3, 8'h00);
        cyc_wait(4);
        drain("count_drain", 10);

        // Count wraps, period 0 treated as 1
        host_wr(2'd0, 8'hFF);
        cfg_period = 0;
        t = cyc;
        push(2'd0, 8'h00, t + 2);
        host_wr(2'd3, 8'h07);
        cyc_wait(2);
        host_wr(2'd3, 8'h00);
        cyc_wait(4);
        drain("wrap_drain", 10);

        // Rotate, period 4, reserved ctrl bits ignored
        host_wr(2'd0, 8'h01);
        cfg_period = 4;
        t = cyc;
        push(2'd0, 8'h02, t + 5);
        push(2'd0, 8'h04, t + 9);
        host_wr(2'd3, 8'hF9);
        cyc_wait(5);
        h_addr = 2'd3;
        #1;
        chk("ctrl_rd", h_rdata, 8'h01);
        chk("seq_active_on", seq_active, 1'b1);
        cyc_wait(4);
        host_wr(2'd3, 8'h00);
        chk("seq_active_off", seq_active, 1'b0);
        cyc_wait(4);
        drain("rot_drain", 10);

        // Bounce from 0x40, then from a zero seed
        host_wr(2'd0, 8'h40);
        cfg_period = 1;
        push(2'd0, 8'h80, -1);
        push(2'd0, 8'h40, -1);
        push(2'd0, 8'h20, -1);
        push(2'd0, 8'h10, -1);
        push(2'd0, 8'h08, -1);
        push(2'd0, 8'h04, -1);
        push(2'd0, 8'h02, -1);
        push(2'd0, 8'h01, -1);
        push(2'd0, 8'h02, -1);
        push(2'd0, 8'h04, -1);
        host_wr(2'd3, 8'h03);
        drain("bounce_seq", 40);
        host_wr(2'd3, 8'h00);
        cyc_wait(4);
        host_wr(2'd0, 8'h00);
        push(2'd0, 8'h01, -1);
        host_wr(2'd3, 8'h03);
        drain("bounce_zero", 10);
        host_wr(2'd3, 8'h00);
        cyc_wait(4);
        drain("bounce_idle", 2);

        // Host holds the port across a pending step
        host_wr(2'd0, 8'h01);
        cfg_period = 2;
        drops = 0;
        t = cyc;
        host_wr(2'd3, 8'h01);
        cyc_wait(2);
        for (int i = 0; i < 6; i++) host_wr(2'd1, 8'h10 + 8'(i));
        push(2'd0, 8'h02, t + 9);
        cyc_wait(1);
        host_wr(2'd3, 8'h00);
        chk("drop_count", drops, 3);
        cyc_wait(4);
        drain("host_hold_drain", 10);
        h_addr = 2'd1;
        #1;
        chk("rgba_readback", h_rdata, 8'h15);

        // EN cleared with a step pending, then resume from retained pattern
        cfg_period = 3;
        host_wr(2'd3, 8'h01);
        cyc_wait(3);
        host_wr(2'd3, 8'h00);
        cyc_wait(8);
        drain("clear_pending", 2);
        t = cyc;
        push(2'd0, 8'h10, t + 4);
        host_wr(2'd3, 8'h01);
        cyc_wait(4);
        host_wr(2'd3, 8'h00);
        cyc_wait(4);
        drain("resume_drain", 10);
        h_addr = 2'd0;
        #1;
        chk("resume_readback", h_rdata, 8'h10);

        // Blink
        host_wr(2'd0, 8'h0F);
        cfg_period = 4;
        t = cyc;
        push(2'd0, 8'hF0, t + 5);
        push(2'd0, 8'h0F, t + 9);
        host_wr(2'd3, 8'h05);
        cyc_wait(9);
        host_wr(2'd3, 8'h00);
        cyc_wait(4);
        drain("blink_drain", 10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
